// File: rtl/controle_entrada_if.sv
// Button/command bundle between the input panel side and the conditioning stage.
// control is a step command: a nonzero value is valid for exactly one clk cycle and
// is always consumed (no ready); the downstream controller moves the car one step per pulse.
interface controle_entrada_if;
    logic       btn_right;
    logic       btn_left;
    logic       enable;
    logic [1:0] control;
    logic [1:0] pressed;
    logic [1:0] state_dbg;

    modport master (
        output btn_right, btn_left, enable,
        input  control, pressed, state_dbg
    );

    modport slave (
        input  btn_right, btn_left, enable,
        output control, pressed, state_dbg
    );
endinterface

// File: rtl/controle_entrada.sv
// Synchronises and debounces the left/right buttons and turns the debounced levels
// into one-cycle move pulses with press-then-auto-repeat timing.
module controle_entrada #(
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter int REPEAT_DELAY_CYCLES = 15000000,
    parameter int REPEAT_RATE_CYCLES  = 2500000
) (
    input logic              clk,
    input logic              reset,
    controle_entrada_if.slave bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LOAD = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RATE_LOAD  = RPT_W'(REPEAT_RATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRE   = 2'd1,
        WAIT   = 2'd2,
        REPEAT = 2'd3
    } state_t;

    // Bit 1 is the right button, bit 0 the left one, matching pressed.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            pressed_q, pressed_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    state_t                state_q, state_d;
    logic [1:0]            dir_q, dir_d;
    logic [RPT_W-1:0]      rpt_q, rpt_d;
    logic [1:0]            control_q, control_d;
    logic [1:0]            req;

    always_comb begin
        sync1_d = {bus.btn_right, bus.btn_left};
        sync2_d = sync1_q;
    end

    always_comb begin
        pressed_d = pressed_q;
        db_cnt_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != pressed_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    pressed_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Both buttons held cancel each other out.
    assign req = (pressed_q == 2'b10 || pressed_q == 2'b01) ? pressed_q : 2'b00;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rpt_d     = rpt_q;
        control_d = 2'b00;

        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        state_d = FIRE;
                        dir_d   = req;
                    end
                end
                FIRE, WAIT, REPEAT: begin
                    if (req == 2'b00) begin
                        state_d = IDLE;
                    end else if (req != dir_q) begin
                        state_d = FIRE;
                        dir_d   = req;
                    end else if (state_q == WAIT && rpt_q == '0) begin
                        state_d = REPEAT;
                    end else begin
                        state_d = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Loading on entry to a pulse and counting through the pulse cycle itself
        // places the next pulse exactly DELAY/RATE cycles after the current one.
        case (state_d)
            FIRE:    rpt_d = DELAY_LOAD;
            REPEAT:  rpt_d = RATE_LOAD;
            default: if (rpt_q != '0) rpt_d = rpt_q - 1'b1;
        endcase

        if (state_d == FIRE || state_d == REPEAT) begin
            control_d = dir_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pressed_q <= '0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            dir_q     <= '0;
            rpt_q     <= '0;
            control_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pressed_q <= pressed_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            rpt_q     <= rpt_d;
            control_q <= control_d;
        end
    end

    assign bus.control   = control_q;
    assign bus.pressed   = pressed_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_controle_entrada.sv
// Bench for controle_entrada: per-cycle comparison against a timing model of the
// button rules, a table of press/release phases, and hand-written corner sequences.
module tb_controle_entrada;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic reset;

    controle_entrada_if bus_if ();

    controle_entrada #(
        .DEBOUNCE_CYCLES     (D),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_RATE_CYCLES  (RR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    bit   [1:0] raw_hist[$];
    logic [1:0] m_pressed;
    logic [1:0] m_dir;
    bit         m_active;
    int         m_elapsed;

    logic [1:0] last_ctrl;
    logic [1:0] last_pressed;

    typedef struct {
        bit         r;
        bit         l;
        bit         en;
        int         cycles;
        int         pulses;
        int         first;
        logic [1:0] pressed_end;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_hist.delete();
        exp_q.delete();
        m_pressed = 2'b00;
        m_dir     = 2'b00;
        m_active  = 1'b0;
        m_elapsed = 0;
    endtask

    // One clock edge of the reference: pulse at elapsed 0, then RD, RD+RR, ...
    // A level is accepted once the last D synchronised samples (raw delayed by two
    // edges) all disagree with it.
    task automatic model_step(input bit r, input bit l, input bit en, output logic [3:0] e);
        logic [1:0] req;
        logic [1:0] ctrl;
        bit         stable;
        bit         v;
        int         n;
        int         idx;
        req  = (en && (m_pressed == 2'b10 || m_pressed == 2'b01)) ? m_pressed : 2'b00;
        ctrl = 2'b00;
        if (req == 2'b00) begin
            m_active = 1'b0;
        end else if (!m_active || req != m_dir) begin
            m_active  = 1'b1;
            m_dir     = req;
            m_elapsed = 0;
            ctrl      = req;
        end else begin
            m_elapsed++;
            if (m_elapsed >= RD && (m_elapsed - RD) % RR == 0) ctrl = req;
        end
        raw_hist.push_back({r, l});
        n = raw_hist.size() - 1;
        for (int b = 0; b < 2; b++) begin
            stable = 1'b1;
            for (int k = 0; k < D; k++) begin
                idx = n - 2 - k;
                v   = (idx >= 0) ? raw_hist[idx][b] : 1'b0;
                if (v == m_pressed[b]) stable = 1'b0;
            end
            if (stable) m_pressed[b] = ~m_pressed[b];
        end
        e = {m_pressed, ctrl};
    endtask

    task automatic drive(input bit r, input bit l, input bit en);
        bus_if.btn_right = r;
        bus_if.btn_left  = l;
        bus_if.enable    = en;
    endtask

    task automatic tick();
        logic [3:0] e;
        model_step(bus_if.btn_right, bus_if.btn_left, bus_if.enable, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        last_ctrl    = bus_if.control;
        last_pressed = bus_if.pressed;
        check("cycle", {bus_if.pressed, bus_if.control}, exp_q.pop_front());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int first;
        int run;
        bit lvl;

        // {right, left, enable, cycles, pulses, first pulse index, pressed at end}
        tbl[0]  = '{1, 0, 1, 30, 6,  6, 2'b10};
        tbl[1]  = '{0, 0, 1, 12, 2,  1, 2'b00};
        tbl[2]  = '{0, 1, 1,  8, 1,  6, 2'b01};
        tbl[3]  = '{0, 0, 1, 12, 0, -1, 2'b00};
        tbl[4]  = '{1, 0, 0, 10, 0, -1, 2'b10};
        tbl[5]  = '{1, 0, 1, 12, 2,  0, 2'b10};
        tbl[6]  = '{0, 0, 1, 12, 2,  1, 2'b00};
        tbl[7]  = '{1, 0, 1,  8, 1,  6, 2'b10};
        tbl[8]  = '{1, 1, 1, 10, 0, -1, 2'b11};
        tbl[9]  = '{0, 1, 1, 12, 1,  6, 2'b01};
        tbl[10] = '{0, 1, 1, 12, 3,  4, 2'b01};
        tbl[11] = '{0, 0, 1, 12, 2,  1, 2'b00};
        tbl[12] = '{0, 0, 1,  4, 0, -1, 2'b00};

        // Clock/reset
        reset = 1'b1;
        drive(0, 0, 1);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus_if.pressed, bus_if.control}, 4'h0);
        #2;
        reset = 1'b0;
        tick();
        check("first_cycle_after_reset", last_ctrl, 2'b00);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].r, tbl[i].l, tbl[i].en);
            pulses = 0;
            first  = -1;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                tick();
                if (last_ctrl != 2'b00) begin
                    if (first < 0) first = c;
                    pulses++;
                end
            end
            check($sformatf("row%0d_pulses", i), pulses, tbl[i].pulses);
            check($sformatf("row%0d_first", i), first, tbl[i].first);
            check($sformatf("row%0d_pressed", i), last_pressed, tbl[i].pressed_end);
        end

        // Bounce: runs of 1..3 cycles must never be accepted
        lvl = 1'b1;
        run = 0;
        while (run < 20) begin
            int len;
            len = $urandom_range(1, 3);
            drive(0, lvl, 1);
            for (int c = 0; c < len; c++) begin
                tick();
                check("bounce", {last_pressed, last_ctrl}, 4'h0);
            end
            run += len;
            lvl = ~lvl;
        end
        drive(0, 0, 1);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("bounce_settle", {last_pressed, last_ctrl}, 4'h0);
        end

        // Asynchronous reset in the middle of WAIT
        drive(1, 0, 1);
        repeat (12) tick();
        check("pre_reset_pressed", last_pressed, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {bus_if.pressed, bus_if.control}, 4'h0);
        #4;
        reset = 1'b0;
        model_reset();
        first = -1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (last_ctrl != 2'b00 && first < 0) first = c;
        end
        check("reset_first_pulse", first, D + 2);

        // Randomised phases against the model
        for (int s = 0; s < 40; s++) begin
            int len;
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) != 0);
            len = $urandom_range(1, 25);
            repeat (len) tick();
        end
        drive(0, 0, 1);
        repeat (20) tick();
        check("final_idle", {last_pressed, last_ctrl}, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
